pic_int_gateway: RTL



---
 rtl/pic_int_gateway_pkg.sv | 12 +
 rtl/pic_int_gateway_if.sv | 22 ++
 rtl/pic_gw_src.sv | 56 +++++
 rtl/pic_sync_dff.sv | 18 +
 rtl/pic_int_gateway.sv | 84 ++++++++
 5 files changed

// File: rtl/pic_int_gateway_pkg.sv
// rtl/pic_int_gateway_pkg.sv - shared PIC definitions: gateway state encoding and default priority width
package pic_int_gateway_pkg;

  localparam int PIC_PRIO_W = 3;

  typedef enum logic [1:0] {
    GW_IDLE  = 2'b00,
    GW_PEND  = 2'b01,
    GW_INSRV = 2'b10
  } gw_state_t;

endpackage

// File: rtl/pic_int_gateway_if.sv
// rtl/pic_int_gateway_if.sv - core-side claim/complete handshake of the interrupt gateway
interface pic_int_gateway_if #(
  parameter int ID_W   = 3,
  parameter int PRIO_W = 3
);
  logic              claim_vld;
  logic              cmplt_vld;
  logic [ID_W-1:0]   cmplt_id;
  logic              int_req;
  logic [ID_W-1:0]   int_id;
  logic [PRIO_W-1:0] int_prio;

  modport master (
    output claim_vld, cmplt_vld, cmplt_id,
    input  int_req, int_id, int_prio
  );

  modport slave (
    input  claim_vld, cmplt_vld, cmplt_id,
    output int_req, int_id, int_prio
  );
endinterface

// File: rtl/pic_gw_src.sv
// rtl/pic_gw_src.sv - per-source gateway FSM with edge detect and repend flag
module pic_gw_src
  import pic_int_gateway_pkg::*;
(
  input  logic clk,
  input  logic rst_b,
  input  logic s,
  input  logic cfg_edge,
  input  logic claim,
  input  logic cmplt,
  output logic pend
);
  gw_state_t state, state_nxt;
  logic      s_d;
  logic      edge_mode;
  logic      repend, repend_nxt;
  logic      rise;

  assign rise = s & ~s_d;

  // Trigger mode is sampled only while idle so a live cfg_edge change cannot
  // alter a source that is already pending or in service.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state     <= GW_IDLE;
      s_d       <= 1'b0;
      edge_mode <= 1'b0;
      repend    <= 1'b0;
    end else begin
      state  <= state_nxt;
      s_d    <= s;
      repend <= repend_nxt;
      if (state == GW_IDLE) edge_mode <= cfg_edge;
    end
  end

  always_comb begin
    state_nxt  = state;
    repend_nxt = repend;
    case (state)
      GW_IDLE:  if (cfg_edge ? rise : s) state_nxt = GW_PEND;
      GW_PEND:  if (claim) state_nxt = GW_INSRV;
      GW_INSRV: begin
        if (cmplt) begin
          repend_nxt = 1'b0;
          state_nxt  = ((edge_mode && repend) || rise) ? GW_PEND : GW_IDLE;
        end else if (rise) begin
          repend_nxt = 1'b1;
        end
      end
      default:  state_nxt = GW_IDLE;
    endcase
  end

  assign pend = (state == GW_PEND);
endmodule

// File: rtl/pic_sync_dff.sv
// rtl/pic_sync_dff.sv - multi-flop synchronizer for one asynchronous line
module pic_sync_dff #(
  parameter int FLOP_NUM = 2
) (
  input  logic clk,
  input  logic rst_b,
  input  logic d,
  output logic q
);
  logic [FLOP_NUM-1:0] ff;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) ff <= '0;
    else        ff <= {ff[FLOP_NUM-2:0], d};
  end

  assign q = ff[FLOP_NUM-1];
endmodule

// File: rtl/pic_int_gateway.sv
// rtl/pic_int_gateway.sv - interrupt gateway array with registered highest-priority arbiter
module pic_int_gateway
  import pic_int_gateway_pkg::*;
#(
  parameter int SRC_NUM  = 8,
  parameter int PRIO_W   = PIC_PRIO_W,
  parameter int SYNC_NUM = 3,
  parameter int ID_W     = $clog2(SRC_NUM)
) (
  input  logic                      clk,
  input  logic                      rst_b,
  input  logic [SRC_NUM-1:0]        int_src,
  input  logic [SRC_NUM-1:0]        cfg_edge,
  input  logic [SRC_NUM-1:0]        cfg_en,
  input  logic [SRC_NUM*PRIO_W-1:0] cfg_prio,
  input  logic [PRIO_W-1:0]         cfg_thresh,
  pic_int_gateway_if.slave          core
);
  logic [SRC_NUM-1:0] s;
  logic [SRC_NUM-1:0] pend;
  logic [SRC_NUM-1:0] elig;
  logic               claim_fire;
  logic               best_vld;
  logic [ID_W-1:0]    best_id;
  logic [PRIO_W-1:0]  best_prio;
  logic               int_req_q;
  logic [ID_W-1:0]    int_id_q;
  logic [PRIO_W-1:0]  int_prio_q;

  assign claim_fire = core.claim_vld & int_req_q;

  for (genvar i = 0; i < SRC_NUM; i++) begin : g_src
    pic_sync_dff #(.FLOP_NUM(SYNC_NUM)) u_sync (
      .clk   (clk),
      .rst_b (rst_b),
      .d     (int_src[i]),
      .q     (s[i])
    );

    pic_gw_src u_gw (
      .clk      (clk),
      .rst_b    (rst_b),
      .s        (s[i]),
      .cfg_edge (cfg_edge[i]),
      .claim    (claim_fire && (int_id_q == ID_W'(i))),
      .cmplt    (core.cmplt_vld && (core.cmplt_id == ID_W'(i))),
      .pend     (pend[i])
    );

    assign elig[i] = pend[i] & cfg_en[i] & (cfg_prio[i*PRIO_W +: PRIO_W] > cfg_thresh);
  end

  // Strict greater-than keeps the lowest index on equal priorities.
  always_comb begin
    best_vld  = 1'b0;
    best_id   = '0;
    best_prio = '0;
    for (int i = 0; i < SRC_NUM; i++) begin
      if (elig[i] && (!best_vld || (cfg_prio[i*PRIO_W +: PRIO_W] > best_prio))) begin
        best_vld  = 1'b1;
        best_id   = ID_W'(i);
        best_prio = cfg_prio[i*PRIO_W +: PRIO_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      int_req_q  <= 1'b0;
      int_id_q   <= '0;
      int_prio_q <= '0;
    end else begin
      int_req_q <= best_vld & ~claim_fire;
      if (best_vld) begin
        int_id_q   <= best_id;
        int_prio_q <= best_prio;
      end
    end
  end

  assign core.int_req  = int_req_q;
  assign core.int_id   = int_id_q;
  assign core.int_prio = int_prio_q;
endmodule
